// File: rtl/multicycle_seq.sv
// multicycle_seq: FETCH/DECODE/EXEC/WB sequencer for the multi-cycle RV32 datapath.
// Drives the PC/IR/register-file strobes, ALU source/op selects, the
// instruction-memory handshake, halt detection and a saturating retire counter.
module multicycle_seq #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      instr_i,
  input  logic             imem_ready_i,
  output logic             imem_req_o,
  output logic             ir_we_o,
  output logic             pc_we_o,
  output logic             reg_we_o,
  output logic             alu_src_o,
  output logic [1:0]       alu_op_o,
  output logic             busy_o,
  output logic             halted_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] retired_o
);

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_alu_src;
  logic [1:0]       r_alu_op;
  logic             r_illegal;
  logic [CNT_W-1:0] r_retired;

  logic             w_load_alu;
  logic             w_alu_src_nxt;
  logic [1:0]       w_alu_op_nxt;
  logic             w_set_illegal;
  logic             w_retire;
  logic [6:0]       w_opcode;

  assign w_opcode = instr_i[6:0];

  // State register; reset parks the sequencer in IDLE from any state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode plus the combinational strobes and register-update enables.
  always_comb begin
    w_next        = r_state;
    imem_req_o    = 1'b0;
    ir_we_o       = 1'b0;
    pc_we_o       = 1'b0;
    reg_we_o      = 1'b0;
    w_load_alu    = 1'b0;
    w_alu_src_nxt = r_alu_src;
    w_alu_op_nxt  = r_alu_op;
    w_set_illegal = 1'b0;
    w_retire      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) w_next = S_FETCH;
      end
      S_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ready_i) begin
          ir_we_o = 1'b1;
          w_next  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (instr_i == 32'h0000_0000) begin
          w_next = S_HALT;
        end else if (w_opcode == OPC_R) begin
          w_load_alu    = 1'b1;
          w_alu_src_nxt = 1'b0;
          w_alu_op_nxt  = 2'b10;
          w_next        = S_EXEC;
        end else if (w_opcode == OPC_I) begin
          w_load_alu    = 1'b1;
          w_alu_src_nxt = 1'b1;
          w_alu_op_nxt  = 2'b11;
          w_next        = S_EXEC;
        end else begin
          // Unsupported opcode: skip it by advancing the PC, no writeback.
          pc_we_o       = 1'b1;
          w_set_illegal = 1'b1;
          w_next        = start_i ? S_FETCH : S_IDLE;
        end
      end
      S_EXEC: begin
        w_next = S_WB;
      end
      S_WB: begin
        reg_we_o = 1'b1;
        pc_we_o  = 1'b1;
        w_retire = 1'b1;
        w_next   = start_i ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // ALU selects, sticky illegal flag and saturating retire counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_alu_src <= 1'b0;
      r_alu_op  <= 2'b00;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      if (w_load_alu) begin
        r_alu_src <= w_alu_src_nxt;
        r_alu_op  <= w_alu_op_nxt;
      end
      if (w_set_illegal) r_illegal <= 1'b1;
      if (w_retire && (r_retired != {CNT_W{1'b1}})) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  assign alu_src_o = r_alu_src;
  assign alu_op_o  = r_alu_op;
  assign illegal_o = r_illegal;
  assign retired_o = r_retired;
  assign busy_o    = (r_state != S_IDLE) && (r_state != S_HALT);
  assign halted_o  = (r_state == S_HALT);

endmodule

// File: tb/tb_multicycle_seq.sv
// Directed bench for multicycle_seq; a CNT_W=4 copy shares the stimulus to
// exercise counter saturation.
module tb_multicycle_seq;

  localparam logic [31:0] INS_R   = 32'h002081B3;
  localparam logic [31:0] INS_I   = 32'h00A08093;
  localparam logic [31:0] INS_BAD = 32'h0000007F;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        ready = 1'b0;

  logic        req, irwe, pcwe, regwe, asrc, busy, halted, illegal;
  logic [1:0]  aop;
  logic [31:0] retired;

  logic        req4, irwe4, pcwe4, regwe4, asrc4, busy4, halted4, illegal4;
  logic [1:0]  aop4;
  logic [3:0]  retired4;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  multicycle_seq #(.CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .instr_i(instr), .imem_ready_i(ready),
    .imem_req_o(req), .ir_we_o(irwe), .pc_we_o(pcwe), .reg_we_o(regwe),
    .alu_src_o(asrc), .alu_op_o(aop), .busy_o(busy), .halted_o(halted),
    .illegal_o(illegal), .retired_o(retired)
  );

  multicycle_seq #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .instr_i(instr), .imem_ready_i(ready),
    .imem_req_o(req4), .ir_we_o(irwe4), .pc_we_o(pcwe4), .reg_we_o(regwe4),
    .alu_src_o(asrc4), .alu_op_o(aop4), .busy_o(busy4), .halted_o(halted4),
    .illegal_o(illegal4), .retired_o(retired4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // strobes packed as {imem_req, ir_we, pc_we, reg_we}
  task automatic chk_s(input string tag, input logic [3:0] exp);
    chk(tag, 32'({req, irwe, pcwe, regwe}), 32'(exp));
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    start = 1'b0;
    tick();
    #1;
    chk_s("rst_strobes", 4'b0000);
    chk("rst_state", 32'({busy, halted, illegal, asrc, aop}), 32'd0);
    chk("rst_retired", retired, 32'd0);
    rst = 1'b0;
  endtask

  // Current cycle must be FETCH; walks FETCH/DECODE/EXEC/WB with ready high.
  task automatic run_legal(input logic [31:0] ins, input logic keep, input string tag);
    instr = ins;
    ready = 1'b1;
    #1;
    chk_s({tag, "_fetch"}, 4'b1100);
    tick();
    #1;
    chk_s({tag, "_decode"}, 4'b0000);
    tick();
    #1;
    chk_s({tag, "_exec"}, 4'b0000);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    tick();
    start = keep;
    #1;
    chk_s({tag, "_wb"}, 4'b0011);
    tick();
  endtask

  initial begin
    logic [3:0] acc;

    // Three back-to-back R-type instructions.
    do_reset();
    start = 1'b1;
    ready = 1'b1;
    instr = INS_R;
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    tick();
    run_legal(INS_R, 1'b1, "r1");
    chk("r1_retired", retired, 32'd1);
    run_legal(INS_R, 1'b1, "r2");
    run_legal(INS_R, 1'b0, "r3");
    #1;
    chk("r3_idle_busy", 32'(busy), 32'd0);
    chk("r3_retired", retired, 32'd3);
    chk("r3_alu", 32'({asrc, aop}), 32'b010);

    // I-type with five not-ready FETCH cycles.
    do_reset();
    start = 1'b1;
    ready = 1'b0;
    instr = INS_I;
    tick();
    acc = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      #1;
      acc = acc | {req, irwe, pcwe, regwe};
      tick();
    end
    chk("wait_strobes", 32'(acc), 32'b1000);
    run_legal(INS_I, 1'b0, "itype");
    #1;
    chk("itype_alu", 32'({asrc, aop}), 32'b111);
    chk("itype_retired", retired, 32'd1);

    // Illegal opcode then a legal R-type.
    start = 1'b1;
    tick();
    instr = INS_BAD;
    ready = 1'b1;
    #1;
    chk_s("ill_fetch", 4'b1100);
    tick();
    #1;
    chk_s("ill_decode", 4'b0010);
    chk("ill_pre", 32'(illegal), 32'd0);
    tick();
    #1;
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_retired", retired, 32'd1);
    chk("ill_alu_held", 32'({asrc, aop}), 32'b111);
    run_legal(INS_R, 1'b0, "post_ill");
    #1;
    chk("post_ill_retired", retired, 32'd2);
    chk("post_ill_alu", 32'({asrc, aop}), 32'b010);
    chk("post_ill_sticky", 32'(illegal), 32'd1);

    // Halt after two instructions.
    do_reset();
    start = 1'b1;
    tick();
    run_legal(INS_R, 1'b1, "h1");
    run_legal(INS_I, 1'b1, "h2");
    instr = 32'h0;
    #1;
    chk_s("halt_fetch", 4'b1100);
    tick();
    #1;
    chk_s("halt_decode", 4'b0000);
    tick();
    #1;
    chk("halt_flags", 32'({halted, busy}), 32'b10);
    acc = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      instr = INS_R;
      #1;
      acc = acc | {req, irwe, pcwe, regwe};
      tick();
    end
    chk("halt_quiet", 32'(acc), 32'd0);
    chk("halt_retired", retired, 32'd2);
    chk("halt_stay", 32'(halted), 32'd1);
    do_reset();

    // start_i dropped in EXEC, then reset during a FETCH wait.
    start = 1'b1;
    ready = 1'b1;
    instr = INS_R;
    tick();
    tick();
    tick();
    start = 1'b0;
    #1;
    chk_s("drop_exec", 4'b0000);
    tick();
    #1;
    chk_s("drop_wb", 4'b0011);
    tick();
    #1;
    chk("drop_idle", 32'(busy), 32'd0);
    chk("drop_retired", retired, 32'd1);
    start = 1'b1;
    ready = 1'b0;
    tick();
    #1;
    chk_s("mid_fetch", 4'b1000);
    rst = 1'b1;
    tick();
    #1;
    chk_s("mid_rst_strobes", 4'b0000);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Saturation on the 4-bit counter copy.
    do_reset();
    start = 1'b1;
    ready = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      run_legal(INS_R, (i < 15) ? 1'b1 : 1'b0, "sat");
      if (i == 14) chk("sat15", 32'(retired4), 32'hF);
    end
    #1;
    chk("sat16", 32'(retired4), 32'hF);
    chk("wide16", retired, 32'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
